// File: rtl/data_cache_pkg.sv
// Shared types and geometry constants for the set-associative write-back data cache.
package data_cache_pkg;
    localparam int WORD_W            = 32;
    localparam int ADDR_W            = 32;
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 2;
    localparam int DEF_WAY_CNT       = 2;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } cache_state_t;

    function automatic int tag_len(input int line_len, input int set_len);
        return ADDR_W - 2 - line_len - set_len;
    endfunction

    function automatic int line_w(input int line_len);
        return WORD_W << line_len;
    endfunction
endpackage

// File: rtl/cache_lru.sv
// Per-set victim picker: lowest invalid way, else the oldest way by age counters.
// Ages update one cycle after an access strobe; the victim output is combinational.
module cache_lru
    import data_cache_pkg::*;
#(
    parameter int WAY_CNT = DEF_WAY_CNT,
    parameter int WAY_W   = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_acc_vld,
    input  logic [WAY_W-1:0]   i_acc_way,
    input  logic [WAY_CNT-1:0] i_way_valid,
    output logic [WAY_W-1:0]   o_victim
);
    generate
        if (WAY_CNT == 1) begin : g_direct
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_acc_vld, i_acc_way, i_way_valid};
            assign o_victim = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] r_age [WAY_CNT];
            logic [WAY_W-1:0] w_lru;

            // Ages stay a permutation of 0..WAY_CNT-1, so the oldest way has the maximum age.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int w = 0; w < WAY_CNT; w++) r_age[w] <= WAY_W'(w);
                end else if (i_acc_vld) begin
                    for (int w = 0; w < WAY_CNT; w++) begin
                        if (WAY_W'(w) == i_acc_way)
                            r_age[w] <= '0;
                        else if (r_age[w] < r_age[i_acc_way])
                            r_age[w] <= r_age[w] + 1'b1;
                    end
                end
            end

            always_comb begin
                w_lru = '0;
                for (int w = 0; w < WAY_CNT; w++)
                    if (r_age[w] == WAY_W'(WAY_CNT - 1)) w_lru = WAY_W'(w);
                o_victim = w_lru;
                for (int w = WAY_CNT - 1; w >= 0; w--)
                    if (!i_way_valid[w]) o_victim = WAY_W'(w);
            end
        end
    endgenerate
endmodule

// File: rtl/data_cache.sv
// Write-back, write-allocate set-associative data cache; zero-latency hits, miss stalls the core
// until the victim is written back (if dirty) and the line is refilled from memory.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int WAY_CNT       = DEF_WAY_CNT,
    parameter int TAG_ADDR_LEN  = tag_len(LINE_ADDR_LEN, SET_ADDR_LEN),
    parameter int LINE_W        = line_w(LINE_ADDR_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_req,
    input  logic              i_wr_req,
    input  logic [31:0]       i_addr,
    input  logic [3:0]        i_wr_be,
    input  logic [31:0]       i_wr_data,
    output logic [31:0]       o_rd_data,
    output logic              o_miss,
    output logic              o_mem_rd_req,
    output logic              o_mem_wr_req,
    output logic [31:0]       o_mem_addr,
    output logic [LINE_W-1:0] o_mem_wr_line,
    input  logic [LINE_W-1:0] i_mem_rd_line,
    input  logic              i_mem_gnt
);
    localparam int SET_CNT = 1 << SET_ADDR_LEN;
    localparam int WAY_W   = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam int OFF_W   = LINE_ADDR_LEN + 2;

    cache_state_t            r_state;
    logic                    r_mem_rd_req, r_mem_wr_req;
    logic [31:0]             r_mem_addr;
    logic [SET_ADDR_LEN-1:0] r_set;
    logic [TAG_ADDR_LEN-1:0] r_req_tag;
    logic [WAY_W-1:0]        r_vway;
    logic [LINE_W-1:0]       r_fill;
    logic [TAG_ADDR_LEN-1:0] r_tag   [SET_CNT][WAY_CNT];
    logic [WAY_CNT-1:0]      r_valid [SET_CNT];
    logic [WAY_CNT-1:0]      r_dirty [SET_CNT];
    logic [LINE_W-1:0]       r_line  [SET_CNT][WAY_CNT];

    logic [LINE_ADDR_LEN-1:0] w_word;
    logic [SET_ADDR_LEN-1:0]  w_set, w_acc_set;
    logic [TAG_ADDR_LEN-1:0]  w_tag;
    logic                     w_req, w_hit_any, w_hit, w_acc_vld;
    logic [WAY_W-1:0]         w_hit_way, w_acc_way, w_vic;
    logic [WAY_W-1:0]         w_victim [SET_CNT];
    logic [LINE_W-1:0]        w_hit_line;
    logic [31:0]              w_old_word, w_wr_word;
    logic                     w_unused;

    assign w_unused = ^i_addr[1:0];
    assign w_word   = i_addr[OFF_W-1:2];
    assign w_set    = i_addr[OFF_W+SET_ADDR_LEN-1:OFF_W];
    assign w_tag    = i_addr[31:OFF_W+SET_ADDR_LEN];
    assign w_req    = i_rd_req | i_wr_req;

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit      = ~i_rst & w_req & w_hit_any & (r_state == IDLE);
    assign o_miss     = ~i_rst & w_req & ~w_hit;
    assign w_hit_line = r_line[w_set][w_hit_way];
    assign w_old_word = w_hit_line[{w_word, 5'b00000} +: 32];
    assign o_rd_data  = w_hit ? w_old_word : 32'h0;

    always_comb begin
        w_wr_word = w_old_word;
        for (int b = 0; b < 4; b++)
            if (i_wr_be[b]) w_wr_word[8*b +: 8] = i_wr_data[8*b +: 8];
    end

    // LRU is touched by hits in IDLE and by the install cycle of a fill.
    assign w_acc_vld = w_hit | (r_state == SWAP_IN_OK);
    assign w_acc_set = (r_state == SWAP_IN_OK) ? r_set  : w_set;
    assign w_acc_way = (r_state == SWAP_IN_OK) ? r_vway : w_hit_way;

    genvar gs;
    generate
        for (gs = 0; gs < SET_CNT; gs++) begin : g_set
            cache_lru #(.WAY_CNT(WAY_CNT), .WAY_W(WAY_W)) u_lru (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_acc_vld   (w_acc_vld && (w_acc_set == SET_ADDR_LEN'(gs))),
                .i_acc_way   (w_acc_way),
                .i_way_valid (r_valid[gs]),
                .o_victim    (w_victim[gs])
            );
        end
    endgenerate

    assign w_vic = w_victim[w_set];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_mem_rd_req <= 1'b0;
            r_mem_wr_req <= 1'b0;
            r_mem_addr   <= '0;
            r_set        <= '0;
            r_req_tag    <= '0;
            r_vway       <= '0;
            r_fill       <= '0;
            for (int s = 0; s < SET_CNT; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAY_CNT; w++) r_tag[s][w] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit && i_wr_req) r_dirty[w_set][w_hit_way] <= 1'b1;
                    // Miss context is latched so a dropped request still completes the fill.
                    if (w_req && !w_hit_any) begin
                        r_set     <= w_set;
                        r_req_tag <= w_tag;
                        r_vway    <= w_vic;
                        if (r_valid[w_set][w_vic] && r_dirty[w_set][w_vic]) begin
                            r_state      <= SWAP_OUT;
                            r_mem_wr_req <= 1'b1;
                            r_mem_addr   <= {r_tag[w_set][w_vic], w_set, {OFF_W{1'b0}}};
                        end else begin
                            r_state      <= SWAP_IN;
                            r_mem_rd_req <= 1'b1;
                            r_mem_addr   <= {w_tag, w_set, {OFF_W{1'b0}}};
                        end
                    end
                end
                SWAP_OUT: begin
                    if (i_mem_gnt) begin
                        r_state      <= SWAP_IN;
                        r_mem_wr_req <= 1'b0;
                        r_mem_rd_req <= 1'b1;
                        r_mem_addr   <= {r_req_tag, r_set, {OFF_W{1'b0}}};
                    end
                end
                SWAP_IN: begin
                    if (i_mem_gnt) begin
                        r_state      <= SWAP_IN_OK;
                        r_mem_rd_req <= 1'b0;
                        r_fill       <= i_mem_rd_line;
                    end
                end
                SWAP_IN_OK: begin
                    r_state                 <= IDLE;
                    r_valid[r_set][r_vway]  <= 1'b1;
                    r_dirty[r_set][r_vway]  <= 1'b0;
                    r_tag[r_set][r_vway]    <= r_req_tag;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_hit && i_wr_req)
            r_line[w_set][w_hit_way][{w_word, 5'b00000} +: 32] <= w_wr_word;
        else if (r_state == SWAP_IN_OK)
            r_line[r_set][r_vway] <= r_fill;
    end

    assign o_mem_rd_req  = r_mem_rd_req;
    assign o_mem_wr_req  = r_mem_wr_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wr_line = r_line[r_set][r_vway];
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios plus random loads/stores on two geometries,
// checked against a flat-memory model with a recency-list replacement model.
module tb_data_cache;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req = 1'b0, wr_req = 1'b0;
    logic [31:0]   addr = '0, wdata = '0;
    logic [3:0]    be = '0;
    logic [LW-1:0] mem_rd_line = '0;
    logic          mem_gnt = 1'b0;
    logic          sel = 1'b0;

    logic [31:0]   d0_rd_data, d1_rd_data, d0_mem_addr, d1_mem_addr;
    logic          d0_miss, d1_miss, d0_mrd, d1_mrd, d0_mwr, d1_mwr;
    logic [LW-1:0] d0_wline, d1_wline;

    wire [31:0]   rd_data    = sel ? d1_rd_data  : d0_rd_data;
    wire          miss       = sel ? d1_miss     : d0_miss;
    wire          mem_rd_req = sel ? d1_mrd      : d0_mrd;
    wire          mem_wr_req = sel ? d1_mwr      : d0_mwr;
    wire [31:0]   mem_addr   = sel ? d1_mem_addr : d0_mem_addr;
    wire [LW-1:0] mem_wr_line = sel ? d1_wline   : d0_wline;

    always #5 clk = ~clk;

    data_cache dut (
        .i_clk(clk), .i_rst(rst), .i_rd_req(rd_req & ~sel), .i_wr_req(wr_req & ~sel),
        .i_addr(addr), .i_wr_be(be), .i_wr_data(wdata), .o_rd_data(d0_rd_data),
        .o_miss(d0_miss), .o_mem_rd_req(d0_mrd), .o_mem_wr_req(d0_mwr),
        .o_mem_addr(d0_mem_addr), .o_mem_wr_line(d0_wline), .i_mem_rd_line(mem_rd_line),
        .i_mem_gnt(mem_gnt & ~sel)
    );

    data_cache #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(1), .WAY_CNT(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_rd_req(rd_req & sel), .i_wr_req(wr_req & sel),
        .i_addr(addr), .i_wr_be(be), .i_wr_data(wdata), .o_rd_data(d1_rd_data),
        .o_miss(d1_miss), .o_mem_rd_req(d1_mrd), .o_mem_wr_req(d1_mwr),
        .o_mem_addr(d1_mem_addr), .o_mem_wr_line(d1_wline), .i_mem_rd_line(mem_rd_line),
        .i_mem_gnt(mem_gnt & sel)
    );

    int checks = 0, errors = 0;
    int nsets, nways, sbits;
    bit m_valid [4][4];
    bit m_dirty [4][4];
    int m_tag   [4][4];
    int m_order [4][$];
    logic [LW-1:0] truth   [int];
    logic [LW-1:0] backing [int];
    logic [31:0] last_wb;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] fresh(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a * 32'h9E3779B1 + i * 32'h01010101 + 32'h1234;
        return l;
    endfunction

    function automatic logic [LW-1:0] get_truth(input logic [31:0] a);
        if (truth.exists(int'(a))) return truth[int'(a)];
        return fresh(a);
    endfunction

    function automatic int victim(input int s);
        for (int w = 0; w < nways; w++) if (!m_valid[s][w]) return w;
        return m_order[s][m_order[s].size() - 1];
    endfunction

    task automatic touch(input int s, input int w);
        for (int i = 0; i < m_order[s].size(); i++)
            if (m_order[s][i] == w) begin m_order[s].delete(i); break; end
        m_order[s].push_front(w);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_order[s].delete();
            for (int w = 0; w < 4; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
            for (int w = 0; w < nways; w++) m_order[s].push_back(w);
        end
        truth = backing;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b1; wr_req = 1'b0; mem_gnt = 1'b0;
        #1;
        chk("rst_miss", miss, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_mem_rd_req", mem_rd_req, 1'b0);
        chk("rst_mem_wr_req", mem_wr_req, 1'b0);
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b0;
        model_reset();
    endtask

    task automatic wait_mem(input bit want_wr);
        bit ok = 0;
        for (int i = 0; i < 16; i++) begin
            if (want_wr ? mem_wr_req : mem_rd_req) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        chk(want_wr ? "wr_req_seen" : "rd_req_seen", ok, 1'b1);
    endtask

    task automatic pulse_gnt();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
    endtask

    task automatic access(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        int s, t, hw, vw, wi;
        bit hit;
        logic [31:0] la, wba;
        logic [LW-1:0] line;
        s  = int'((a >> 5) & (nsets - 1));
        t  = int'(a >> (5 + sbits));
        la = a & ~32'h1f;
        wi = int'((a >> 2) & 7);
        hit = 0; hw = 0;
        for (int k = 0; k < nways; k++)
            if (m_valid[s][k] && m_tag[s][k] == t) begin hit = 1; hw = k; end
        @(negedge clk);
        rd_req = !w; wr_req = w; addr = a; be = b; wdata = d;
        mem_gnt = hit && ($urandom_range(0, 3) == 0);
        #1;
        chk("miss_flag", miss, !hit);
        if (!hit) begin
            vw = victim(s);
            if (m_valid[s][vw] && m_dirty[s][vw]) begin
                wba = 32'(m_tag[s][vw] << (5 + sbits)) | 32'(s << 5);
                wait_mem(1'b1);
                chk("wb_addr", mem_addr, wba);
                chk("wb_line", mem_wr_line, get_truth(wba));
                chk("wb_excl", mem_rd_req, 1'b0);
                last_wb = mem_addr;
                backing[int'(wba)] = get_truth(wba);
                pulse_gnt();
            end
            wait_mem(1'b0);
            chk("fill_addr", mem_addr, la);
            chk("fill_excl", mem_wr_req, 1'b0);
            mem_rd_line = get_truth(la);
            pulse_gnt();
            chk("install_stall", miss, 1'b1);
            chk("install_no_req", mem_rd_req, 1'b0);
            @(negedge clk); #1;
            chk("post_fill_hit", miss, 1'b0);
            m_valid[s][vw] = 1; m_dirty[s][vw] = 0; m_tag[s][vw] = t;
            hw = vw;
            touch(s, vw);
        end
        touch(s, hw);
        line = get_truth(la);
        if (!w) begin
            chk("rd_data", rd_data, line[wi*32 +: 32]);
        end else begin
            for (int k = 0; k < 4; k++) if (b[k]) line[wi*32 + k*8 +: 8] = d[k*8 +: 8];
            truth[int'(la)] = line;
            m_dirty[s][hw] = 1;
        end
    endtask

    task automatic rand_run(input int n, input int ntags);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, ntags - 1) << (5 + sbits)) |
                32'($urandom_range(0, nsets - 1) << 5) | 32'($urandom_range(0, 7) << 2);
            access($urandom_range(0, 1) == 1, a, 4'($urandom_range(1, 15)), $urandom);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; nsets = 4; nways = 2; sbits = 2;
        do_reset();

        access(0, 32'h40, 4'h0, 32'h0);
        access(1, 32'h44, 4'b0011, 32'hDEADBEEF);
        access(0, 32'h44, 4'h0, 32'h0);

        do_reset();
        last_wb = 32'hFFFF_FFFF;
        access(1, 32'h000, 4'hF, 32'h1111_2222);
        access(0, 32'h080, 4'h0, 32'h0);
        access(0, 32'h100, 4'h0, 32'h0);
        chk("lru_wb_two_way", last_wb, 32'h000);

        do_reset();
        last_wb = 32'hFFFF_FFFF;
        access(1, 32'h080, 4'hF, 32'hCAFE_0080);
        access(0, 32'h000, 4'h0, 32'h0);
        access(0, 32'h080, 4'h0, 32'h0);
        access(1, 32'h000, 4'hF, 32'hCAFE_0000);
        access(0, 32'h100, 4'h0, 32'h0);
        chk("lru_wb_alternate", last_wb, 32'h080);

        do_reset();
        @(negedge clk);
        rd_req = 1'b1; wr_req = 1'b0; addr = 32'h40;
        #1;
        wait_mem(1'b0);
        rst = 1'b1;
        #1;
        chk("abort_rd_req", mem_rd_req, 1'b0);
        chk("abort_miss", miss, 1'b0);
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b0;
        model_reset();
        access(0, 32'h40, 4'h0, 32'h0);

        rand_run(150, 6);

        sel = 1'b1; nsets = 2; nways = 4; sbits = 1;
        do_reset();
        last_wb = 32'hFFFF_FFFF;
        access(1, 32'h000, 4'hF, 32'h4444_0000);
        access(0, 32'h040, 4'h0, 32'h0);
        access(0, 32'h080, 4'h0, 32'h0);
        access(0, 32'h0C0, 4'h0, 32'h0);
        access(0, 32'h100, 4'h0, 32'h0);
        chk("lru_wb_four_way", last_wb, 32'h000);

        rand_run(150, 8);

        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0; mem_gnt = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
